// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler: latches floor presses into a pending bitmap and feeds the elevator FSM its next target.
// Optional door-dwell hold at each served floor is enabled by defining SCHED_DWELL_EN.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int DWELL_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_floor,
  input  logic        req_valid,
  input  logic [3:0]  current_floor,
  output logic [3:0]  requested_floor,
  output logic [15:0] pending,
  output logic        dir_up,
  output logic        busy,
  output logic        door_open
);

  typedef enum logic [1:0] {IDLE, SERVE, DWELL} state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] floor;
    logic       dir_up;
  } sel_t;

  localparam logic [4:0] NF5 = 5'(NUM_FLOORS);

  state_t      state, state_n;
  sel_t        sel;
  logic [3:0]  requested_n;
  logic        dir_n;
  logic        arrive;
  logic        req_ok;
  logic [15:0] set_mask, clr_mask, pending_n;

  logic       up_ge_hit, up_gt_hit, dn_le_hit, dn_lt_hit;
  logic [3:0] up_ge, up_gt, dn_le, dn_lt;

  // Nearest pending floor on each side of the car; descending scans keep the lowest, ascending keep the highest.
  always_comb begin
    up_ge_hit = 1'b0; up_ge = '0;
    up_gt_hit = 1'b0; up_gt = '0;
    dn_le_hit = 1'b0; dn_le = '0;
    dn_lt_hit = 1'b0; dn_lt = '0;
    for (int f = 15; f >= 0; f--) begin
      if (pending[f] && 4'(f) >= current_floor) begin up_ge_hit = 1'b1; up_ge = 4'(f); end
      if (pending[f] && 4'(f) >  current_floor) begin up_gt_hit = 1'b1; up_gt = 4'(f); end
    end
    for (int f = 0; f < 16; f++) begin
      if (pending[f] && 4'(f) <= current_floor) begin dn_le_hit = 1'b1; dn_le = 4'(f); end
      if (pending[f] && 4'(f) <  current_floor) begin dn_lt_hit = 1'b1; dn_lt = 4'(f); end
    end
  end

  always_comb begin
    sel = '{hit: 1'b0, floor: requested_floor, dir_up: dir_up};
    if (dir_up) begin
      if (up_ge_hit)      sel = '{hit: 1'b1, floor: up_ge, dir_up: 1'b1};
      else if (dn_lt_hit) sel = '{hit: 1'b1, floor: dn_lt, dir_up: 1'b0};
    end else begin
      if (dn_le_hit)      sel = '{hit: 1'b1, floor: dn_le, dir_up: 1'b0};
      else if (up_gt_hit) sel = '{hit: 1'b1, floor: up_gt, dir_up: 1'b1};
    end
  end

  assign arrive = (state == SERVE) && (current_floor == requested_floor) && pending[requested_floor];

  // Presses at or above NUM_FLOORS never reach the bitmap, so its upper bits stay zero.
  always_comb begin
    req_ok = req_valid && ({1'b0, req_floor} < NF5);
`ifdef SCHED_DWELL_EN
    if (state == DWELL && req_floor == current_floor) req_ok = 1'b0;
`endif
  end

  assign set_mask  = req_ok ? (16'b1 << req_floor) : 16'b0;
  assign clr_mask  = arrive ? (16'b1 << requested_floor) : 16'b0;
  assign pending_n = (pending | set_mask) & ~clr_mask;

`ifdef SCHED_DWELL_EN
  localparam int         CW      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DW_LOAD = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] dwell_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                dwell_cnt <= '0;
    else if (arrive)                          dwell_cnt <= DW_LOAD;
    else if (state == DWELL && dwell_cnt != 0) dwell_cnt <= dwell_cnt - 1'b1;
  end
`endif

  always_comb begin
    state_n     = state;
    requested_n = requested_floor;
    dir_n       = dir_up;
    case (state)
      IDLE: begin
        if (sel.hit) begin
          requested_n = sel.floor;
          dir_n       = sel.dir_up;
          state_n     = SERVE;
        end
      end
      SERVE: begin
        if (arrive) begin
`ifdef SCHED_DWELL_EN
          state_n = DWELL;
`else
          state_n = IDLE;
`endif
        end else if (!sel.hit) begin
          state_n = IDLE;
        end else begin
          requested_n = sel.floor;
          dir_n       = sel.dir_up;
        end
      end
      DWELL: begin
`ifdef SCHED_DWELL_EN
        if (dwell_cnt == 0) state_n = IDLE;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      requested_floor <= '0;
      pending         <= '0;
      dir_up          <= 1'b1;
    end else begin
      state           <= state_n;
      requested_floor <= requested_n;
      pending         <= pending_n;
      dir_up          <= dir_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef SCHED_DWELL_EN
  assign door_open = (state == DWELL);
`else
  assign door_open = 1'b0;
`endif

endmodule
